pb_event: RTL and testbench
===========================

Name: pb_event

Overview:
- Consumer-side companion to the push-button debouncer: takes the clean debounced button level and turns it into single-cycle event strobes.
- Strobes: press, release, long-press, and typematic auto-repeat. Also reports how long the button has been held, in milliseconds.
- Sits between the debouncer output and control logic such as counters, menu FSMs and register-file steppers, which act on clean one-cycle pulses.

Parameters:
- CLK_PER_MS, 50000, clk cycles per 1 ms tick (50 MHz board clock); legal minimum 2
- LONG_MS, 1000, hold time in ms before long_press fires; legal 1..2^CNT_W-1
- REPEAT_MS, 200, ms between successive repeat strobes after long_press; legal 1..2^CNT_W-1
- CNT_W, 16, width of hold_ms and the internal ms counters

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pb_level  in  1  debounced button level, 1 = pressed; not assumed synchronous to clk
- press  out  1  one-cycle strobe on press
- release  out  1  one-cycle strobe on release
- long_press  out  1  one-cycle strobe when hold reaches LONG_MS
- repeat  out  1  one-cycle strobe every REPEAT_MS after long_press while still held
- held  out  1  registered synchronized button state
- hold_ms  out  CNT_W  ms elapsed since press; saturating

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, hold_ms 0, state IDLE, sync flops 0, prescaler 0.
- Input path: 2-flop synchronizer, then a registered previous-value flop for edge detection.
  - Rising edge of pb_level → press high on the 3rd rising clk edge after the change.
  - Falling edge behaves the same for release.
- Reset released while pb_level is already high: press IS generated. Sync flops reset to 0, so this is a legitimate edge.
- ms tick: free-running prescaler counting 0..CLK_PER_MS-1.
  - tick is high for one clk when the count equals CLK_PER_MS-1, then the count wraps to 0.
  - The prescaler is NOT cleared on press, so the first tick after press arrives 1..CLK_PER_MS cycles later.
- FSM states:
  - IDLE: held=0, hold_ms=0. On synced rising edge: press=1, hold_ms←0, go HELD.
  - HELD: held=1. Each tick: hold_ms←hold_ms+1, saturating at all-ones. When hold_ms reaches LONG_MS (on the tick that makes it equal): long_press=1, rep_cnt←0, go REPEAT.
  - REPEAT: held=1, hold_ms keeps counting. Each tick: rep_cnt+1. When rep_cnt reaches REPEAT_MS: repeat=1, rep_cnt←0.
- Synced falling edge in HELD or REPEAT: release=1, go IDLE. hold_ms keeps its final value for that one cycle, then reads 0.
- Simultaneous release edge and threshold tick in the same cycle: release wins. No long_press or repeat in that cycle.
- Strobes are mutually exclusive and each lasts exactly one clk. press and release are never high in the same cycle.
- Sync-stage glitches shorter than 1 clk are not filtered. Filtering is the debouncer's job.
- All outputs are registered; there are no combinational input→output paths.

Decomposition:
- Shared header pb_defs.vh: FSM state encodings (ST_IDLE=2'd0, ST_HELD=2'd1, ST_REPEAT=2'd2) and the default CLK_PER_MS, so the debouncer and this block share one clock-rate constant.
- One natural sub-module: ms_tick (parameter CLK_PER_MS; ports clk, rst_n, tick). It is a reusable 1 ms strobe generator for a single clock domain.
- Synchronizer, edge detect and FSM stay inline in pb_event.

Test Plan (CLK_PER_MS=4, LONG_MS=5, REPEAT_MS=2, CNT_W=8):
- Short press: pb_level high for 10 clk then low → one press 3 clk after the rise, one release 3 clk after the fall; no long_press; hold_ms ≤ 3.
- Long hold: pb_level high for 40 clk → long_press exactly once, when hold_ms==5; then repeat at hold_ms==7, 9 and so on, about 8 clk apart; single release on the fall.
- Collision: release edge timed to land on the tick that would make hold_ms=5 → release=1, long_press never asserted, state IDLE.
- Reset mid-REPEAT: drop rst_n asynchronously → all outputs 0 immediately. Re-release rst_n with pb_level still high → press 3 clk later, hold_ms restarts at 0.
- Saturation (LONG_MS=250, REPEAT_MS=1): hold 300 ms → hold_ms sticks at 255 with no wrap; repeat keeps firing every tick.
- Strobe checker throughout all scenarios: each strobe is 1 cycle wide; press, release, long_press and repeat never overlap.

Source files
------------

// File: rtl/pb_event_pkg.sv
// Shared definitions for the push-button event block: FSM state encodings
// and the board clock-rate constant shared with the debouncer.
package pb_event_pkg;

    // Encodings are fixed so other blocks and waveform viewers agree on them.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } pb_state_t;

    // 50 MHz board clock: cycles per 1 ms tick.
    localparam int PB_CLK_PER_MS = 50000;

endpackage

// File: rtl/pb_event_ms_tick.sv
// Free-running 1 ms strobe generator for a single clock domain.
// o_tick is high for one clk when the prescaler sits at CLK_PER_MS-1.
module ms_tick
    import pb_event_pkg::*;
#(
    parameter int CLK_PER_MS = PB_CLK_PER_MS
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tick;

    assign w_tick = (r_cnt == LAST);
    assign o_tick = w_tick;

    // Prescaler counts 0..CLK_PER_MS-1 and wraps; never cleared by button activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pb_event.sv
// Push-button event generator: turns a clean debounced level into one-cycle
// press / release / long-press / auto-repeat strobes and a held-time counter.
// All outputs are registered.
module pb_event
    import pb_event_pkg::*;
#(
    parameter int CLK_PER_MS = PB_CLK_PER_MS,
    parameter int LONG_MS    = 1000,
    parameter int REPEAT_MS  = 200,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pb_level,
    output logic             o_press,
    output logic             o_release,
    output logic             o_long_press,
    output logic             o_repeat,
    output logic             o_held,
    output logic [CNT_W-1:0] o_hold_ms
);

    localparam logic [CNT_W-1:0] LONG_THR = CNT_W'(LONG_MS);
    localparam logic [CNT_W-1:0] REP_THR  = CNT_W'(REPEAT_MS);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic             r_sync1, r_sync2, r_prev;
    logic             w_rise, w_fall, w_tick;

    pb_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_hold_ms, w_hold_nxt, w_hold_inc;
    logic [CNT_W-1:0] r_rep_cnt, w_rep_nxt, w_rep_inc;
    logic             r_press, r_release, r_long, r_repeat, r_held;
    logic             w_press_nxt, w_release_nxt, w_long_nxt, w_repeat_nxt, w_held_nxt;

    ms_tick #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_ms_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    // Two-flop synchronizer plus a previous-value flop for edge detection.
    // Flops reset to 0, so a button already down at reset release is a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_pb_level;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_prev;
    assign w_fall = ~r_sync2 & r_prev;

    // Next-state and next-output logic; a release edge overrides any tick work.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_ms;
        w_rep_nxt     = r_rep_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;
        w_hold_inc    = sat_inc(r_hold_ms);
        w_rep_inc     = r_rep_cnt + 1'b1;

        unique case (r_state)
            ST_IDLE: begin
                w_hold_nxt = '0;
                if (w_rise) begin
                    w_press_nxt = 1'b1;
                    w_state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (w_fall) begin
                    w_release_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (w_tick) begin
                    w_hold_nxt = w_hold_inc;
                    if (w_hold_inc == LONG_THR) begin
                        w_long_nxt  = 1'b1;
                        w_rep_nxt   = '0;
                        w_state_nxt = ST_REPEAT;
                    end
                end
            end
            ST_REPEAT: begin
                if (w_fall) begin
                    w_release_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (w_tick) begin
                    w_hold_nxt = w_hold_inc;
                    if (w_rep_inc == REP_THR) begin
                        w_repeat_nxt = 1'b1;
                        w_rep_nxt    = '0;
                    end else begin
                        w_rep_nxt = w_rep_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_held_nxt = (w_state_nxt != ST_IDLE);
    end

    // State, counters and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_hold_ms <= '0;
            r_rep_cnt <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold_ms <= w_hold_nxt;
            r_rep_cnt <= w_rep_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_long    <= w_long_nxt;
            r_repeat  <= w_repeat_nxt;
            r_held    <= w_held_nxt;
        end
    end

    assign o_press      = r_press;
    assign o_release    = r_release;
    assign o_long_press = r_long;
    assign o_repeat     = r_repeat;
    assign o_held       = r_held;
    assign o_hold_ms    = r_hold_ms;

endmodule

// File: tb/tb_pb_event.sv
// Directed bench for pb_event with CLK_PER_MS=4. u_dut uses LONG_MS=5,
// REPEAT_MS=2; u_sat uses LONG_MS=250, REPEAT_MS=1 for saturation.
// cyc counts posedges since reset release; the FSM sees a tick on edges
// where cyc is a multiple of 4.
module tb_pb_event;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       pb    = 1'b0;
    logic       pb2   = 1'b0;

    logic       press, rel, lng, rpt, held;
    logic [7:0] hold_ms;
    logic       press2, rel2, lng2, rpt2, held2;
    logic [7:0] hold2;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    int n_press = 0, n_rel = 0, n_long = 0, n_rep = 0;
    int n_press2 = 0, n_rel2 = 0, n_long2 = 0, n_rep2 = 0;
    int viol = 0;
    int long_hold = 0, long_hold2 = 0;
    int rep_hold[$];
    int rep_cyc[$];

    logic [3:0] s1, s2;
    logic [3:0] prev1 = 4'd0;
    logic [3:0] prev2 = 4'd0;

    always #5 clk = ~clk;

    pb_event #(
        .CLK_PER_MS (4), .LONG_MS (5), .REPEAT_MS (2), .CNT_W (8)
    ) u_dut (
        .clk (clk), .rst_n (rst_n), .i_pb_level (pb),
        .o_press (press), .o_release (rel), .o_long_press (lng),
        .o_repeat (rpt), .o_held (held), .o_hold_ms (hold_ms)
    );

    pb_event #(
        .CLK_PER_MS (4), .LONG_MS (250), .REPEAT_MS (1), .CNT_W (8)
    ) u_sat (
        .clk (clk), .rst_n (rst_n), .i_pb_level (pb2),
        .o_press (press2), .o_release (rel2), .o_long_press (lng2),
        .o_repeat (rpt2), .o_held (held2), .o_hold_ms (hold2)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    assign s1 = {press, rel, lng, rpt};
    assign s2 = {press2, rel2, lng2, rpt2};

    // Strobe monitor: counts pulses, records context, flags overlap or width > 1.
    always @(negedge clk) begin
        if (($countones(s1) > 1) || ($countones(s2) > 1)) viol <= viol + 1;
        else if (((s1 & prev1) != 4'd0) || ((s2 & prev2) != 4'd0)) viol <= viol + 1;
        prev1 <= s1;
        prev2 <= s2;
        if (press === 1'b1) n_press <= n_press + 1;
        if (rel   === 1'b1) n_rel   <= n_rel + 1;
        if (lng   === 1'b1) begin n_long <= n_long + 1; long_hold <= int'(hold_ms); end
        if (rpt   === 1'b1) begin
            n_rep <= n_rep + 1;
            rep_hold.push_back(int'(hold_ms));
            rep_cyc.push_back(cyc);
        end
        if (press2 === 1'b1) n_press2 <= n_press2 + 1;
        if (rel2   === 1'b1) n_rel2   <= n_rel2 + 1;
        if (lng2   === 1'b1) begin n_long2 <= n_long2 + 1; long_hold2 <= int'(hold2); end
        if (rpt2   === 1'b1) n_rep2 <= n_rep2 + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 8 && (cyc % 4) != ph; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        step(2);
        checks++; if ({press, rel, lng, rpt, held, hold_ms} !== 13'd0) begin
            fails++; $display("FAIL reset_dut: got %b want 0", {press, rel, lng, rpt, held, hold_ms}); end
        checks++; if ({press2, rel2, lng2, rpt2, held2, hold2} !== 13'd0) begin
            fails++; $display("FAIL reset_sat: got %b want 0", {press2, rel2, lng2, rpt2, held2, hold2}); end
        rst_n = 1'b1;
        step(4);
        checks++; if ({press, held, hold_ms} !== 10'd0) begin
            fails++; $display("FAIL reset_idle: got %b want 0", {press, held, hold_ms}); end
    endtask

    task automatic test_short_press();
        int p0, r0, l0;
        p0 = n_press; r0 = n_rel; l0 = n_long;
        pb = 1'b1;
        step(2);
        checks++; if (press !== 1'b0) begin fails++; $display("FAIL sp_press_early: got %b want 0", press); end
        step(1);
        checks++; if ({press, held} !== 2'b11) begin fails++; $display("FAIL sp_press_3rd: got %b want 11", {press, held}); end
        step(1);
        checks++; if (press !== 1'b0) begin fails++; $display("FAIL sp_press_width: got %b want 0", press); end
        step(6);
        pb = 1'b0;
        step(2);
        checks++; if (rel !== 1'b0) begin fails++; $display("FAIL sp_release_early: got %b want 0", rel); end
        step(1);
        checks++; if ({rel, held} !== 2'b10) begin fails++; $display("FAIL sp_release_3rd: got %b want 10", {rel, held}); end
        checks++; if (hold_ms > 8'd3) begin fails++; $display("FAIL sp_hold_max: got %0d want <=3", hold_ms); end
        step(1);
        checks++; if (hold_ms !== 8'd0) begin fails++; $display("FAIL sp_hold_clear: got %0d want 0", hold_ms); end
        step(3);
        checks++; if ({n_press - p0, n_rel - r0, n_long - l0} !== {32'd1, 32'd1, 32'd0}) begin
            fails++; $display("FAIL sp_counts: got press=%0d rel=%0d long=%0d want 1 1 0", n_press - p0, n_rel - r0, n_long - l0); end
    endtask

    task automatic test_long_hold();
        int r0, l0, qi;
        r0 = n_rel; l0 = n_long; qi = rep_hold.size();
        pb = 1'b1;
        step(40);
        pb = 1'b0;
        step(3);
        checks++; if (rel !== 1'b1) begin fails++; $display("FAIL lh_release: got %b want 1", rel); end
        step(3);
        checks++; if (n_long - l0 != 1) begin fails++; $display("FAIL lh_long_count: got %0d want 1", n_long - l0); end
        checks++; if (long_hold != 5) begin fails++; $display("FAIL lh_long_hold: got %0d want 5", long_hold); end
        checks++; if (rep_hold.size() - qi != 2) begin fails++; $display("FAIL lh_repeat_count: got %0d want 2", rep_hold.size() - qi); end
        if (rep_hold.size() >= qi + 2) begin
            checks++; if (rep_hold[qi] != 7) begin fails++; $display("FAIL lh_rep1_hold: got %0d want 7", rep_hold[qi]); end
            checks++; if (rep_hold[qi+1] != 9) begin fails++; $display("FAIL lh_rep2_hold: got %0d want 9", rep_hold[qi+1]); end
            checks++; if (rep_cyc[qi+1] - rep_cyc[qi] != 8) begin
                fails++; $display("FAIL lh_rep_spacing: got %0d want 8", rep_cyc[qi+1] - rep_cyc[qi]); end
        end
        checks++; if (n_rel - r0 != 1) begin fails++; $display("FAIL lh_release_count: got %0d want 1", n_rel - r0); end
    endtask

    task automatic test_collision();
        int l0;
        l0 = n_long;
        wait_phase(1);
        pb = 1'b1;
        step(20);
        checks++; if ({held, hold_ms} !== {1'b1, 8'd4}) begin
            fails++; $display("FAIL col_pre: got held=%b hold=%0d want 1 4", held, hold_ms); end
        pb = 1'b0;
        step(3);
        checks++; if ({rel, lng} !== 2'b10) begin fails++; $display("FAIL col_release_wins: got %b want 10", {rel, lng}); end
        checks++; if (hold_ms !== 8'd4) begin fails++; $display("FAIL col_hold_kept: got %0d want 4", hold_ms); end
        step(1);
        checks++; if ({held, hold_ms} !== 9'd0) begin fails++; $display("FAIL col_idle: got held=%b hold=%0d want 0 0", held, hold_ms); end
        step(8);
        checks++; if (n_long - l0 != 0) begin fails++; $display("FAIL col_no_long: got %0d want 0", n_long - l0); end
    endtask

    task automatic test_reset_mid_repeat();
        int l0;
        l0 = n_long;
        pb = 1'b1;
        step(30);
        checks++; if ({held, n_long - l0} !== {1'b1, 32'd1}) begin
            fails++; $display("FAIL rr_in_repeat: got held=%b long=%0d want 1 1", held, n_long - l0); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({press, rel, lng, rpt, held, hold_ms} !== 13'd0) begin
            fails++; $display("FAIL rr_async_clear: got %b want 0", {press, rel, lng, rpt, held, hold_ms}); end
        step(2);
        rst_n = 1'b1;
        step(2);
        checks++; if (press !== 1'b0) begin fails++; $display("FAIL rr_press_early: got %b want 0", press); end
        step(1);
        checks++; if ({press, held, hold_ms} !== {2'b11, 8'd0}) begin
            fails++; $display("FAIL rr_press: got press=%b held=%b hold=%0d want 1 1 0", press, held, hold_ms); end
        step(5);
        checks++; if (hold_ms !== 8'd2) begin fails++; $display("FAIL rr_hold_restart: got %0d want 2", hold_ms); end
        pb = 1'b0;
        step(3);
        checks++; if (rel !== 1'b1) begin fails++; $display("FAIL rr_release: got %b want 1", rel); end
        step(3);
    endtask

    task automatic test_saturation();
        int r0;
        pb2 = 1'b1;
        step(3);
        checks++; if (press2 !== 1'b1) begin fails++; $display("FAIL sat_press: got %b want 1", press2); end
        step(1250);
        checks++; if (hold2 !== 8'd255) begin fails++; $display("FAIL sat_hold: got %0d want 255", hold2); end
        checks++; if ({n_long2, long_hold2} !== {32'd1, 32'd250}) begin
            fails++; $display("FAIL sat_long: got count=%0d hold=%0d want 1 250", n_long2, long_hold2); end
        r0 = n_rep2;
        step(40);
        checks++; if (hold2 !== 8'd255) begin fails++; $display("FAIL sat_no_wrap: got %0d want 255", hold2); end
        checks++; if (n_rep2 - r0 != 10) begin fails++; $display("FAIL sat_repeat_rate: got %0d want 10", n_rep2 - r0); end
        pb2 = 1'b0;
        step(3);
        checks++; if (rel2 !== 1'b1) begin fails++; $display("FAIL sat_release: got %b want 1", rel2); end
        step(2);
    endtask

    task automatic test_strobes();
        checks++; if (viol != 0) begin fails++; $display("FAIL strobe_rules: got %0d violations want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_hold();
        test_collision();
        test_reset_mid_repeat();
        test_saturation();
        test_strobes();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
